hi_lo_unit: RTL and testbench
=============================

HI_LO_UNIT -- requirements
Module: hi_lo_unit

Interface
REQ-001 Parameter: ITER_CYCLES, 32, iteration count for multiply/divide; fixed at 32 for this block.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request strobe; accepted only when Busy=0.
REQ-005 Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved.
REQ-006 OperandA  input  32  rs value: multiplicand / dividend / MTHI-MTLO source.
REQ-007 OperandB  input  32  rt value: multiplier / divisor.
REQ-008 ReadReq  input  1  a downstream MFHI/MFLO is in decode this cycle.
REQ-009 ReadDataHi  output  32  registered HI value, fed to the writeback HI/LO select.
REQ-010 ReadDataLo  output  32  registered LO value, fed to the writeback HI/LO select.
REQ-011 Busy  output  1  registered; multiply/divide in progress.
REQ-012 Done  output  1  registered one-cycle pulse; new HI/LO visible this cycle.
REQ-013 Stall  output  1  combinational: (ReadReq | Start) & Busy.

Function
REQ-014 States are IDLE, RUN and FIX.
REQ-015 IDLE with Start and Op 0-3: latch operands, clear count, go to RUN, Busy=1 next cycle.
REQ-016 RUN performs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes, for exactly 32 cycles, then goes to FIX.
REQ-017 FIX applies sign correction, writes HI/LO on its closing edge, returns to IDLE, and sets Busy=0 and Done=1 in the following cycle.
REQ-018 Latency: Start accepted on edge E0 -> Busy high for 33 cycles -> HI/LO updated and Done pulsed after edge E33.
REQ-019 MULT/MULTU: {HI,LO} = full 64-bit product; signed for MULT, unsigned for MULTU.
REQ-020 DIV/DIVU: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign (signed case).
REQ-021 Divide by zero: HI = OperandA, LO = 0xFFFFFFFF; timing is unchanged (33 cycles).
REQ-022 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-023 MTHI/MTLO in IDLE: write only the selected register on the next edge, leave the other unchanged; Busy stays 0 and Done stays 0.
REQ-024 Start while Busy=1 (any Op) is ignored, with no state change; Stall=1 that cycle.
REQ-025 Reserved Op with Start: no effect.
REQ-026 ReadDataHi/ReadDataLo hold their previous values throughout RUN/FIX, and both update atomically on the same edge.
REQ-027 A Start in the same cycle as Done=1 is accepted normally (Busy is already 0).

Reset
REQ-028 Reset forces state IDLE, HI=0, LO=0, Busy=0, Done=0 and count=0 on the next edge.
REQ-029 Reset has priority over Start and over any in-flight operation; a mid-RUN reset aborts with no HI/LO write.

Structure
REQ-030 A shared package holds the Op encodings, ITER_CYCLES, and the state encoding.
REQ-031 One sub-module, mul_div_core, holds the iterative datapath: 64-bit accumulator, one step per enable, sign fixup.
REQ-032 hi_lo_unit holds the FSM, counter, HI/LO registers, and the Stall/Done logic.

Verification
REQ-033 MULT A=0xFFFFFFFE, B=0x00000003 -> after 33 cycles Done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; also DIVU A=0x64, B=0 -> HI=0x64, LO=0xFFFFFFFF.
REQ-036 MTHI A=0x12345678 from IDLE -> next cycle ReadDataHi=0x12345678, LO unchanged, Busy=0.
REQ-037 During a MULT, ReadReq=1 plus Start with MTLO at cycle 5 -> Stall=1, MTLO dropped, HI/LO hold old values until Done.
REQ-038 Reset at RUN cycle 10 -> next cycle Busy=0, HI=LO=0, no Done; a subsequent MULT 3*4 gives LO=12, HI=0.

Source files
------------

// File: rtl/hi_lo_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hi_lo_unit_pkg
//  Purpose  : Shared encodings for the HI/LO multiply/divide unit: operation
//             codes, iteration count and FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package hi_lo_unit_pkg;

  localparam int DATA_W      = 32;
  localparam int ITER_CYCLES = 32;
  localparam int CNT_W       = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // True for the four iterative operations that occupy the datapath.
  function automatic logic op_is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Magnitude of a value that may be two's complement; 0x80000000 maps to 2^31.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic             is_signed);
    return (is_signed && v[DATA_W-1]) ? (DATA_W'(0) - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hi_lo_unit_mul_div_core.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_core
//  Purpose  : Iterative 32x32 multiply / 32/32 restoring divide datapath on
//             operand magnitudes, one step per enable, with sign fixup on the
//             combinational result outputs.
//  Revision : 1.0  initial release
// ============================================================================
module mul_div_core
  import hi_lo_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend/quotient bits}.
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_step;
  logic [DATA_W-1:0]   oper;       // multiplicand or divisor magnitude
  logic [DATA_W-1:0]   a_raw;      // original dividend for the divide-by-zero result
  logic                div_mode;
  logic                neg_lo;     // product / quotient must be negated
  logic                neg_hi;     // remainder must be negated
  logic                div_zero;

  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [2*DATA_W-1:0] prod_neg;

  assign mag_a = magnitude(a, is_signed);
  assign mag_b = magnitude(b, is_signed);

  // One shift-add or restoring shift-subtract step.
  always_comb begin
    add_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, oper} : {(DATA_W+1){1'b0}});
    trial    = acc[2*DATA_W-1:DATA_W-1] - {1'b0, oper};
    acc_step = acc;
    if (div_mode) begin
      if (!trial[DATA_W]) begin
        acc_step = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      end else begin
        acc_step = {acc[2*DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_step = {add_sum, acc[DATA_W-1:1]};
    end
  end

  // Operand capture on load, iteration on step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      oper     <= '0;
      a_raw    <= '0;
      div_mode <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      div_mode <= is_div;
      neg_lo   <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_hi   <= is_signed & a[DATA_W-1];
      div_zero <= (b == '0);
      a_raw    <= a;
      if (is_div) begin
        acc  <= {{DATA_W{1'b0}}, mag_a};
        oper <= mag_b;
      end else begin
        acc  <= {{DATA_W{1'b0}}, mag_b};
        oper <= mag_a;
      end
    end else if (step) begin
      acc <= acc_step;
    end
  end

  // Sign correction and divide-by-zero substitution of the final result.
  always_comb begin
    prod_neg = (2*DATA_W)'(0) - acc;
    res_hi   = acc[2*DATA_W-1:DATA_W];
    res_lo   = acc[DATA_W-1:0];
    if (!div_mode) begin
      if (neg_lo) begin
        res_hi = prod_neg[2*DATA_W-1:DATA_W];
        res_lo = prod_neg[DATA_W-1:0];
      end
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = {DATA_W{1'b1}};
    end else begin
      res_lo = neg_lo ? (DATA_W'(0) - acc[DATA_W-1:0]) : acc[DATA_W-1:0];
      res_hi = neg_hi ? (DATA_W'(0) - acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hi_lo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hi_lo_unit
//  Purpose  : HI/LO register file with an iterative multiply/divide engine,
//             MTHI/MTLO writes, and pipeline stall generation.
//  Revision : 1.0  initial release
// ============================================================================
module hi_lo_unit
  import hi_lo_unit_pkg::*;
#(
  parameter int ITER_CYCLES = hi_lo_unit_pkg::ITER_CYCLES
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        Op,
  input  logic [DATA_W-1:0] OperandA,
  input  logic [DATA_W-1:0] OperandB,
  input  logic              ReadReq,
  output logic [DATA_W-1:0] ReadDataHi,
  output logic [DATA_W-1:0] ReadDataLo,
  output logic              Busy,
  output logic              Done,
  output logic              Stall
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  hi;
  logic [DATA_W-1:0]  lo;
  logic               busy;
  logic               done;
  logic               load;
  logic               step;
  logic               idle_start;
  logic [DATA_W-1:0]  core_hi;
  logic [DATA_W-1:0]  core_lo;

  // Starts are only honoured from IDLE; in RUN/FIX they only raise Stall.
  assign idle_start = (state == ST_IDLE) && Start;

  mul_div_core u_core (
    .clk       (Clk),
    .rst       (Reset),
    .load      (load),
    .step      (step),
    .is_div    (op_is_div(Op)),
    .is_signed (op_is_signed(Op)),
    .a         (OperandA),
    .b         (OperandB),
    .res_hi    (core_hi),
    .res_lo    (core_lo)
  );

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (idle_start && op_is_muldiv(Op)) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (count == LAST_STEP) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter, status flags and HI/LO registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      done  <= (state == ST_FIX);
      if (load) begin
        count <= '0;
      end else if (step) begin
        count <= count + 1'b1;
      end
      if (state == ST_FIX) begin
        hi <= core_hi;
        lo <= core_lo;
      end else if (idle_start && (Op == OP_MTHI)) begin
        hi <= OperandA;
      end else if (idle_start && (Op == OP_MTLO)) begin
        lo <= OperandA;
      end
    end
  end

  assign ReadDataHi = hi;
  assign ReadDataLo = lo;
  assign Busy       = busy;
  assign Done       = done;
  assign Stall      = (ReadReq | Start) & busy;

endmodule
`default_nettype wire

// File: tb/tb_hi_lo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hi_lo_unit
//  Purpose  : Directed self-checking bench for hi_lo_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hi_lo_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        ReadReq;
  logic [31:0] ReadDataHi;
  logic [31:0] ReadDataLo;
  logic        Busy;
  logic        Done;
  logic        Stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [12];

  hi_lo_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .ReadReq    (ReadReq),
    .ReadDataHi (ReadDataHi),
    .ReadDataLo (ReadDataLo),
    .Busy       (Busy),
    .Done       (Done),
    .Stall      (Stall)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge: issues the operation, then waits for Done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          n;
    logic        held;
    old_hi   = ReadDataHi;
    old_lo   = ReadDataLo;
    Start    = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    @(negedge Clk);
    Start = 1'b0;
    Op    = 3'd0;
    chk({nm, " busy_after_start"}, {31'd0, Busy}, 32'd1);
    n    = 1;
    held = 1'b1;
    while (!Done && n < 40) begin
      if (ReadDataHi !== old_hi || ReadDataLo !== old_lo) held = 1'b0;
      @(negedge Clk);
      n++;
    end
    chk({nm, " latency"}, n, 34);
    chk({nm, " hold"}, {31'd0, held}, 32'd1);
    chk({nm, " hi"}, ReadDataHi, eh);
    chk({nm, " lo"}, ReadDataLo, el);
    chk({nm, " busy_at_done"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    int          n;
    logic        saw_done;
    logic [31:0] old_hi;
    logic [31:0] old_lo;

    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd0, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
    vecs[6]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};

    Reset = 1'b1; Start = 1'b0; Op = 3'd0; OperandA = '0; OperandB = '0; ReadReq = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk("reset hi", ReadDataHi, 32'd0);
    chk("reset lo", ReadDataLo, 32'd0);
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset done", {31'd0, Done}, 32'd0);
    ReadReq = 1'b1;
    #1 chk("idle readreq stall", {31'd0, Stall}, 32'd0);
    ReadReq = 1'b0;

    // Table-driven multiply/divide vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
    end

    // MTHI from IDLE writes only HI.
    @(negedge Clk);
    old_lo = ReadDataLo;
    Start = 1'b1; Op = 3'd4; OperandA = 32'h12345678;
    @(negedge Clk);
    Start = 1'b0;
    chk("mthi hi", ReadDataHi, 32'h12345678);
    chk("mthi lo", ReadDataLo, old_lo);
    chk("mthi busy", {31'd0, Busy}, 32'd0);
    chk("mthi done", {31'd0, Done}, 32'd0);

    // MTLO writes only LO.
    Start = 1'b1; Op = 3'd5; OperandA = 32'hCAFEF00D;
    @(negedge Clk);
    Start = 1'b0;
    chk("mtlo lo", ReadDataLo, 32'hCAFEF00D);
    chk("mtlo hi", ReadDataHi, 32'h12345678);
    chk("mtlo busy", {31'd0, Busy}, 32'd0);

    // Reserved op has no effect.
    Start = 1'b1; Op = 3'd6; OperandA = 32'hAAAA5555; OperandB = 32'h3;
    @(negedge Clk);
    Op = 3'd7;
    @(negedge Clk);
    Start = 1'b0;
    chk("rsv hi", ReadDataHi, 32'h12345678);
    chk("rsv lo", ReadDataLo, 32'hCAFEF00D);
    chk("rsv busy", {31'd0, Busy}, 32'd0);
    chk("rsv done", {31'd0, Done}, 32'd0);

    // Start with MTLO during a MULT: stalled and dropped, HI/LO held.
    old_hi = ReadDataHi;
    old_lo = ReadDataLo;
    Start = 1'b1; Op = 3'd0; OperandA = 32'd5; OperandB = 32'd6;
    @(negedge Clk);
    Start = 1'b0;
    n = 1;
    repeat (4) @(negedge Clk);
    n = 5;
    ReadReq = 1'b1; Start = 1'b1; Op = 3'd5; OperandA = 32'hDEADBEEF;
    #1 chk("busy stall", {31'd0, Stall}, 32'd1);
    @(negedge Clk);
    n++;
    ReadReq = 1'b0; Start = 1'b0; Op = 3'd0;
    chk("dropped mtlo lo", ReadDataLo, old_lo);
    chk("dropped mtlo hi", ReadDataHi, old_hi);
    chk("busy after drop", {31'd0, Busy}, 32'd1);
    while (!Done && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("stall seq latency", n, 34);
    chk("stall seq hi", ReadDataHi, 32'd0);
    chk("stall seq lo", ReadDataLo, 32'd30);

    // Start on the Done cycle is accepted (back-to-back).
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_first");
    run_op(3'd1, 32'd9, 32'd9, 32'd0, 32'd81, "b2b_second");

    // Reset in the middle of RUN aborts with no HI/LO write.
    @(negedge Clk);
    Start = 1'b1; Op = 3'd1; OperandA = 32'hFFFFFFFF; OperandB = 32'h2;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrun reset busy", {31'd0, Busy}, 32'd0);
    chk("midrun reset hi", ReadDataHi, 32'd0);
    chk("midrun reset lo", ReadDataLo, 32'd0);
    chk("midrun reset done", {31'd0, Done}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done || Busy) saw_done = 1'b1;
    end
    chk("no activity after reset", {31'd0, saw_done}, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 32'd0, 32'd12, "post_reset_mult");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
